// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op/state types, result limits and 7-seg codes for the accumulator sequencer
package alu_seq_pkg;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_e;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_COMMIT, S_ERROR} state_e;
   localparam logic signed [3:0] MIN_VAL = -4'sd4;
   localparam logic signed [3:0] MAX_VAL = 4'sd3;
   localparam logic [7:0] SEG_0   = 8'b0011_1111;
   localparam logic [7:0] SEG_1   = 8'b0000_0110;
   localparam logic [7:0] SEG_2   = 8'b0101_1011;
   localparam logic [7:0] SEG_3   = 8'b0100_1111;
   localparam logic [7:0] SEG_4   = 8'b0110_0110;
   localparam logic [7:0] SEG_OVF = 8'b0011_1111;
   localparam logic [7:0] SEG_UDF = 8'b0011_1110;
   // Sign on bit 7, digit of the magnitude below; -4 negates to 3'b100, read unsigned as 4
   function automatic logic [7:0] seg_encode(input logic signed [2:0] v);
      logic [2:0] m;
      m = v[2] ? -v : v;
      return {v[2], m == 3'd0 ? SEG_0[6:0] : m == 3'd1 ? SEG_1[6:0] : m == 3'd2 ? SEG_2[6:0] :
                    m == 3'd3 ? SEG_3[6:0] : SEG_4[6:0]};
   endfunction
endpackage

// File: rtl/alu_3b.sv
// alu_3b: combinational 3-bit signed ALU producing a 4-bit result with one guard bit
module alu_3b
   import alu_seq_pkg::*;
(
   input  logic signed [2:0] i_a,
   input  logic signed [2:0] i_b,
   input  op_e               i_f,
   output logic signed [3:0] o_y
);
   logic signed [3:0] w_a;
   logic signed [3:0] w_b;
   assign w_a = {i_a[2], i_a};
   assign w_b = {i_b[2], i_b};
   // Bitwise ops on sign-extended operands stay inside -4..3; only add/sub can leave range
   always_comb
      o_y = i_f == OP_ADD ? w_a + w_b :
            i_f == OP_SUB ? w_a - w_b :
            i_f == OP_AND ? w_a & w_b : w_a | w_b;
endmodule

// File: rtl/alu_acc_sequencer.sv
// alu_acc_sequencer: handshaked accumulator calculator with range-checked commit and 7-seg output
module alu_acc_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NBITS_NUM = 3,
   parameter int NBITS_Y   = 4,
   parameter int NBITS_CNT = 4
) (
   input  logic                        clk_2,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        op_valid,
   output logic                        op_ready,
   input  logic [1:0]                  op_code,
   input  logic signed [NBITS_NUM-1:0] operand,
   output logic signed [NBITS_NUM-1:0] acc,
   output logic                        acc_valid,
   output logic                        err_ovf,
   output logic                        err_udf,
   output logic                        busy,
   output logic [NBITS_CNT-1:0]        op_cnt,
   output logic [7:0]                  seg
);
   state_e                      r_state;
   op_e                         r_op;
   logic signed [NBITS_NUM-1:0] r_operand;
   logic signed [NBITS_NUM-1:0] r_acc;
   logic signed [NBITS_Y-1:0]   r_y;
   logic signed [NBITS_Y-1:0]   w_y;
   logic                        r_acc_valid;
   logic                        r_ovf;
   logic                        r_udf;
   logic [NBITS_CNT-1:0]        r_cnt;
   logic [7:0]                  r_seg;

   alu_3b u_alu (
      .i_a (r_acc),
      .i_b (r_operand),
      .i_f (r_op),
      .o_y (w_y)
   );

   assign op_ready  = r_state == S_IDLE;
   assign busy      = r_state != S_IDLE;
   assign acc       = r_acc;
   assign acc_valid = r_acc_valid;
   assign err_ovf   = r_ovf;
   assign err_udf   = r_udf;
   assign op_cnt    = r_cnt;
   assign seg       = r_seg;

   // Accept -> evaluate -> commit or trap; clear overrides every state and drops any pending op
   always_ff @(posedge clk_2 or negedge rst_n)
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_op        <= OP_ADD;
         r_operand   <= '0;
         r_acc       <= '0;
         r_y         <= '0;
         r_acc_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_udf       <= 1'b0;
         r_cnt       <= '0;
         r_seg       <= SEG_0;
      end else if (clear) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_acc_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_udf       <= 1'b0;
         r_cnt       <= '0;
         r_seg       <= SEG_0;
      end else begin
         r_acc_valid <= 1'b0;
         case (r_state)
            S_IDLE:
               if (op_valid) begin
                  r_op      <= op_e'(op_code);
                  r_operand <= operand;
                  r_state   <= S_EXEC;
               end
            S_EXEC: begin
               r_y     <= w_y;
               r_state <= S_COMMIT;
            end
            S_COMMIT:
               if (r_y > MAX_VAL) begin
                  r_ovf   <= 1'b1;
                  r_seg   <= SEG_OVF;
                  r_state <= S_ERROR;
               end else if (r_y < MIN_VAL) begin
                  r_udf   <= 1'b1;
                  r_seg   <= SEG_UDF;
                  r_state <= S_ERROR;
               end else begin
                  r_acc       <= r_y[NBITS_NUM-1:0];
                  r_acc_valid <= 1'b1;
                  r_cnt       <= r_cnt + NBITS_CNT'(r_cnt != '1);
                  r_seg       <= seg_encode(r_y[NBITS_NUM-1:0]);
                  r_state     <= S_IDLE;
               end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_alu_acc_sequencer.sv
// tb_alu_acc_sequencer: scenario tasks plus random ops checked against an integer reference model
module tb_alu_acc_sequencer;
   logic              clk_2 = 1'b0;
   logic              rst_n = 1'b0;
   logic              clear = 1'b0;
   logic              op_valid = 1'b0;
   logic              op_ready;
   logic [1:0]        op_code = 2'd0;
   logic signed [2:0] operand = 3'sd0;
   logic signed [2:0] acc;
   logic              acc_valid;
   logic              err_ovf;
   logic              err_udf;
   logic              busy;
   logic [3:0]        op_cnt;
   logic [7:0]        seg;
   logic [19:0]       obs;

   int errors = 0;
   int checks = 0;
   int m_acc = 0;
   int m_cnt = 0;
   bit m_ovf = 0;
   bit m_udf = 0;

   localparam logic [6:0] DIG [0:4] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66};

   alu_acc_sequencer dut (
      .clk_2     (clk_2),
      .rst_n     (rst_n),
      .clear     (clear),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_code   (op_code),
      .operand   (operand),
      .acc       (acc),
      .acc_valid (acc_valid),
      .err_ovf   (err_ovf),
      .err_udf   (err_udf),
      .busy      (busy),
      .op_cnt    (op_cnt),
      .seg       (seg)
   );

   always #5 clk_2 = ~clk_2;

   assign obs = {acc, acc_valid, err_ovf, err_udf, busy, op_ready, op_cnt, seg};

   function automatic logic [19:0] exp_vec(input logic v);
      logic       e;
      logic [7:0] s;
      e = m_ovf | m_udf;
      s = m_ovf ? 8'h3F : m_udf ? 8'h3E : {m_acc < 0, DIG[m_acc < 0 ? -m_acc : m_acc]};
      return {3'(m_acc), v, m_ovf, m_udf, e, !e, 4'(m_cnt), s};
   endfunction

   function automatic void model_clear();
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 0;
      m_udf = 0;
   endfunction

   task automatic run_op(input logic [1:0] c, input int b);
      int y;
      bit v;
      @(negedge clk_2);
      checks++;
      if ({busy, op_ready} !== 2'b01) begin
         errors++;
         $display("FAIL op_idle: busy/ready=%b expected 01", {busy, op_ready});
      end
      op_valid = 1'b1;
      op_code  = c;
      operand  = 3'(b);
      @(negedge clk_2);
      op_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({acc, acc_valid, busy, op_ready} !== {3'(m_acc), 1'b0, 2'b10}) begin
            errors++;
            $display("FAIL op_inflight%0d: acc/valid/busy/ready=%b expected %b", k,
                     {acc, acc_valid, busy, op_ready}, {3'(m_acc), 1'b0, 2'b10});
         end
         if (k == 0) @(negedge clk_2);
      end
      case (c)
         2'd0:    y = m_acc + b;
         2'd1:    y = m_acc - b;
         2'd2:    y = m_acc & b;
         default: y = m_acc | b;
      endcase
      v = 0;
      if (y > 3) m_ovf = 1;
      else if (y < -4) m_udf = 1;
      else begin
         m_acc = y;
         m_cnt = m_cnt < 15 ? m_cnt + 1 : 15;
         v = 1;
      end
      @(negedge clk_2);
      checks++;
      if (obs !== exp_vec(v)) begin
         errors++;
         $display("FAIL op_result c=%0d b=%0d: got %h expected %h", c, b, obs, exp_vec(v));
      end
      @(negedge clk_2);
      checks++;
      if (obs !== exp_vec(0)) begin
         errors++;
         $display("FAIL op_after c=%0d b=%0d: got %h expected %h", c, b, obs, exp_vec(0));
      end
   endtask

   task automatic do_clear();
      @(negedge clk_2);
      clear = 1'b1;
      @(negedge clk_2);
      clear = 1'b0;
      model_clear();
      checks++;
      if (obs !== exp_vec(0)) begin
         errors++;
         $display("FAIL clear: got %h expected %h", obs, exp_vec(0));
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      op_valid = 1'b1;
      repeat (2) @(negedge clk_2);
      model_clear();
      checks++;
      if (obs !== exp_vec(0)) begin
         errors++;
         $display("FAIL reset_held: got %h expected %h", obs, exp_vec(0));
      end
      rst_n    = 1'b1;
      op_valid = 1'b0;
      @(negedge clk_2);
      checks++;
      if (obs !== exp_vec(0) || seg !== 8'b0011_1111) begin
         errors++;
         $display("FAIL reset_release: got %h expected %h", obs, exp_vec(0));
      end
   endtask

   task automatic test_add();
      run_op(2'd0, 3);
      checks++;
      if (seg !== 8'b0100_1111 || op_cnt !== 4'd1) begin
         errors++;
         $display("FAIL add_seg3: seg=%h cnt=%0d expected 4f 1", seg, op_cnt);
      end
   endtask

   task automatic test_ovf();
      run_op(2'd0, 1);
      op_valid = 1'b1;
      repeat (4) begin
         @(negedge clk_2);
         checks++;
         if (obs !== exp_vec(0)) begin
            errors++;
            $display("FAIL ovf_hold: got %h expected %h", obs, exp_vec(0));
         end
      end
      op_valid = 1'b0;
      do_clear();
   endtask

   task automatic test_udf();
      run_op(2'd0, -4);
      run_op(2'd1, 1);
      checks++;
      if (seg !== 8'b0011_1110 || err_udf !== 1'b1 || acc !== -3'sd4) begin
         errors++;
         $display("FAIL udf_state: seg=%h udf=%b acc=%0d expected 3e 1 -4", seg, err_udf, acc);
      end
      do_clear();
   endtask

   task automatic test_logic();
      run_op(2'd0, -2);
      run_op(2'd2, 3);
      run_op(2'd3, -3);
      checks++;
      if (seg !== 8'h86 || acc !== -3'sd1) begin
         errors++;
         $display("FAIL logic_seg: seg=%h acc=%0d expected 86 -1", seg, acc);
      end
   endtask

   task automatic test_held_valid();
      int pulses;
      do_clear();
      pulses   = 0;
      op_code  = 2'd0;
      operand  = 3'sd1;
      op_valid = 1'b1;
      repeat (9) begin
         @(negedge clk_2);
         if (acc_valid) pulses++;
      end
      op_valid = 1'b0;
      m_acc = 3;
      m_cnt = 3;
      checks++;
      if (pulses != 3 || obs !== exp_vec(1)) begin
         errors++;
         $display("FAIL held_valid: pulses=%0d obs=%h expected 3 %h", pulses, obs, exp_vec(1));
      end
      repeat (4) @(negedge clk_2);
      checks++;
      if (obs !== exp_vec(0)) begin
         errors++;
         $display("FAIL held_quiet: got %h expected %h", obs, exp_vec(0));
      end
   endtask

   task automatic test_async_reset();
      run_op(2'd1, 1);
      @(negedge clk_2);
      op_valid = 1'b1;
      op_code  = 2'd0;
      operand  = 3'sd1;
      @(negedge clk_2);
      op_valid = 1'b0;
      #1 rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (obs !== exp_vec(0)) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", obs, exp_vec(0));
      end
      @(negedge clk_2);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_2);
      checks++;
      if (obs !== exp_vec(0)) begin
         errors++;
         $display("FAIL async_no_commit: got %h expected %h", obs, exp_vec(0));
      end
   endtask

   task automatic test_clear_commit();
      run_op(2'd0, 2);
      @(negedge clk_2);
      op_valid = 1'b1;
      op_code  = 2'd0;
      operand  = 3'sd1;
      @(negedge clk_2);
      op_valid = 1'b0;
      @(negedge clk_2);
      clear = 1'b1;
      @(negedge clk_2);
      clear = 1'b0;
      model_clear();
      checks++;
      if (obs !== exp_vec(0)) begin
         errors++;
         $display("FAIL clear_commit: got %h expected %h", obs, exp_vec(0));
      end
      clear    = 1'b1;
      op_valid = 1'b1;
      operand  = 3'sd2;
      @(negedge clk_2);
      clear    = 1'b0;
      op_valid = 1'b0;
      repeat (3) @(negedge clk_2);
      checks++;
      if (obs !== exp_vec(0)) begin
         errors++;
         $display("FAIL clear_blocks_accept: got %h expected %h", obs, exp_vec(0));
      end
   endtask

   task automatic test_saturate();
      do_clear();
      repeat (16) run_op(2'd0, 0);
      checks++;
      if (op_cnt !== 4'd15) begin
         errors++;
         $display("FAIL cnt_saturate: got %0d expected 15", op_cnt);
      end
   endtask

   task automatic test_random();
      repeat (40) begin
         run_op(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)) - 4);
         if (m_ovf || m_udf) do_clear();
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_ovf();
      test_udf();
      test_logic();
      test_held_valid();
      test_async_reset();
      test_clear_commit();
      test_saturate();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
